// File: rtl/img_tx_sequencer.sv
// Streams a stored image from SRAM to the UART TX byte interface one pixel at a time, in raster order.
// The sequencer keeps one SRAM read outstanding and holds each pixel until the UART accepts it.
module img_tx_sequencer #(
    parameter int unsigned SRAM_ADDR_WIDTH = 20,
    parameter int unsigned PIX_WIDTH       = 8,
    parameter int unsigned SRAM_RD_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_read,
    input  logic [9:0]                 img_height,
    input  logic [9:0]                 img_width,
    input  logic                       img_ready_in_sram,
    output logic                       sram_rd_en,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [PIX_WIDTH-1:0]       sram_rd_data,
    output logic                       tx_valid,
    output logic [PIX_WIDTH-1:0]       tx_data,
    input  logic                       tx_ready,
    output logic [9:0]                 row_cnt,
    output logic [9:0]                 col_cnt,
    output logic                       transfer_complete,
    output logic                       busy,
    output logic                       start_err
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned WAIT_W = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic                       start_prev;
    logic [CNT_W-1:0]           h_q;
    logic [CNT_W-1:0]           w_q;
    logic [CNT_W-1:0]           h_nx;
    logic [CNT_W-1:0]           w_nx;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [WAIT_W-1:0]          wait_nx;
    logic [SRAM_ADDR_WIDTH-1:0] addr_nx;
    logic [CNT_W-1:0]           row_nx;
    logic [CNT_W-1:0]           col_nx;
    logic [PIX_WIDTH-1:0]       data_nx;
    logic                       done_nx;
    logic                       err_nx;

    logic start_edge_c;
    logic geom_ok_c;
    logic last_pix_c;
    logic row_end_c;

    assign start_edge_c = start_read & ~start_prev;
    assign geom_ok_c    = img_ready_in_sram && (img_height != '0) && (img_width != '0);
    assign row_end_c    = CNT_W'(col_cnt + 1'b1) == w_q;
    assign last_pix_c   = (row_cnt == CNT_W'(h_q - 1'b1)) && (col_cnt == CNT_W'(w_q - 1'b1));

    // Next-state and next-value logic for the whole datapath
    always_comb begin
        state_nx = state;
        h_nx     = h_q;
        w_nx     = w_q;
        wait_nx  = wait_cnt;
        addr_nx  = sram_rd_addr;
        row_nx   = row_cnt;
        col_nx   = col_cnt;
        data_nx  = tx_data;
        done_nx  = transfer_complete;
        err_nx   = start_err;
        case (state)
            IDLE: begin
                if (start_edge_c) begin
                    if (geom_ok_c) begin
                        h_nx     = img_height;
                        w_nx     = img_width;
                        addr_nx  = '0;
                        row_nx   = '0;
                        col_nx   = '0;
                        done_nx  = 1'b0;
                        err_nx   = 1'b0;
                        state_nx = REQ;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            REQ: begin
                wait_nx  = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    data_nx  = sram_rd_data;
                    state_nx = SEND;
                end else begin
                    wait_nx = WAIT_W'(wait_cnt + 1'b1);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    addr_nx = SRAM_ADDR_WIDTH'(sram_rd_addr + 1'b1);
                    if (row_end_c) begin
                        col_nx = '0;
                        row_nx = CNT_W'(row_cnt + 1'b1);
                    end else begin
                        col_nx = CNT_W'(col_cnt + 1'b1);
                    end
                    if (last_pix_c) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            start_prev        <= 1'b0;
            h_q               <= '0;
            w_q               <= '0;
            wait_cnt          <= '0;
            sram_rd_en        <= 1'b0;
            sram_rd_addr      <= '0;
            tx_valid          <= 1'b0;
            tx_data           <= '0;
            row_cnt           <= '0;
            col_cnt           <= '0;
            transfer_complete <= 1'b0;
            busy              <= 1'b0;
            start_err         <= 1'b0;
        end else begin
            state             <= state_nx;
            start_prev        <= start_read;
            h_q               <= h_nx;
            w_q               <= w_nx;
            wait_cnt          <= wait_nx;
            sram_rd_en        <= (state_nx == REQ);
            sram_rd_addr      <= addr_nx;
            tx_valid          <= (state_nx == SEND);
            tx_data           <= data_nx;
            row_cnt           <= row_nx;
            col_cnt           <= col_nx;
            transfer_complete <= done_nx;
            busy              <= (state_nx != IDLE);
            start_err         <= err_nx;
        end
    end

endmodule

// File: doc/img_tx_sequencer.md
Name: img_tx_sequencer

Overview:
Sequences the readback of a stored image from SRAM to the UART TX path, one pixel at a time, in raster order.
- Armed by the IMG CTRL start bit (`hw_start_image_read`). Geometry comes from the IMG STATUS height/width fields.
- Drives the IMG TX Monitor fields: row_cnt, col_cnt and transfer_complete.
- Sits between the image register file, the SRAM read port and the UART TX byte interface.

Parameters:
SRAM_ADDR_WIDTH, 20, SRAM word address width; must satisfy 2^SRAM_ADDR_WIDTH >= 1023*1023.
PIX_WIDTH, 8, pixel/byte width.
SRAM_RD_LAT, 2, cycles from sram_rd_en to valid sram_rd_data; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_read  in  1  level from the IMG CTRL start bit; a rising edge requests a transfer
img_height  in  10  image rows, from the IMG STATUS register
img_width  in  10  image columns, from the IMG STATUS register
img_ready_in_sram  in  1  SRAM holds a complete image
sram_rd_en  out  1  one-cycle read strobe
sram_rd_addr  out  SRAM_ADDR_WIDTH  linear pixel address
sram_rd_data  in  PIX_WIDTH  read data, valid SRAM_RD_LAT cycles after sram_rd_en
tx_valid  out  1  pixel available to the UART TX
tx_data  out  PIX_WIDTH  pixel byte
tx_ready  in  1  UART TX accepts the byte
row_cnt  out  10  completed rows
col_cnt  out  10  completed pixels in the current row
transfer_complete  out  1  last pixel handed off
busy  out  1  transfer in progress
start_err  out  1  last start request was rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; state IDLE; start_read edge register = 0.
- Reset asserted mid-transfer: abort immediately. No further sram_rd_en or tx_valid from the cycle after rst is sampled.
- Start detection: rising edge = start_read=1 while the registered previous value = 0. Only edges seen in IDLE are acted on; edges while busy are ignored (no error).
- Start acceptance in IDLE:
  - Accepted if img_ready_in_sram=1, img_height!=0 and img_width!=0.
  - On acceptance: latch height and width; clear row_cnt, col_cnt, address, transfer_complete and start_err; go to REQ.
  - Otherwise: set start_err=1, stay in IDLE, leave transfer_complete unchanged.
- FSM states: IDLE, REQ, WAIT, SEND.
- REQ (1 cycle):
  - sram_rd_en=1, sram_rd_addr = linear address; busy=1 in REQ, WAIT and SEND.
  - Next state is WAIT.
- WAIT (SRAM_RD_LAT cycles, wait counter):
  - sram_rd_data is sampled into tx_data at the clock edge ending the last WAIT cycle.
  - Next state is SEND.
- SEND:
  - tx_valid=1; tx_data held stable until tx_ready=1.
  - tx_valid must not drop without a handshake.
- On handshake (tx_valid && tx_ready):
  - Address increments by 1.
  - If col_cnt+1 == width: col_cnt=0, row_cnt+1. Otherwise col_cnt+1.
  - If this was the last pixel (row_cnt == height-1 and col_cnt == width-1): go to IDLE, transfer_complete=1, busy=0 next cycle. Otherwise go to REQ.
- Final counters: row_cnt=height, col_cnt=0.
- transfer_complete: sticky until the next accepted start or reset.
- Throughput: SRAM_RD_LAT+2 cycles per pixel with tx_ready held at 1. Only one read is outstanding at a time.
- Latency: start edge seen in cycle N → sram_rd_en in N+1 → tx_valid in N+2+SRAM_RD_LAT.
- Input stability: img_height, img_width and img_ready_in_sram changes during a transfer have no effect.
- Counter and address widths: 10-bit counters never exceed 1023 because the latched geometry is ≤1023. Address arithmetic is unsigned and never wraps for legal geometry.

Test Plan:
- H=2, W=3, LAT=2, tx_ready=1, SRAM[i]=0x10+i → 6 reads at addresses 0..5; tx_data 0x10..0x15 in order; 4 cycles per pixel; first tx_valid 4 cycles after the start edge; final row_cnt=2, col_cnt=0, transfer_complete=1, busy=0.
- Same image with tx_ready low 5 cycles on pixel 2 → tx_valid/tx_data held 0x12 through the stall; no extra sram_rd_en; totals unchanged.
- start_read rising with width=0, or with img_ready_in_sram=0 → no sram_rd_en, start_err=1, busy stays 0. A following valid start clears start_err.
- Second start_read edge mid-transfer, with img_width changed to 5 → ignored; transfer completes with 6 pixels.
- rst=1 during a WAIT cycle of pixel 3 → all outputs 0 the next cycle. A new start begins again at address 0.
- H=1, W=1 → exactly one read at address 0 and one handshake; row_cnt=1, col_cnt=0, transfer_complete=1.
